// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit period is latched on handshake; TX is registered and trails the state by one cycle.
module uart_tx #(
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [20:0] prescaler_in,
  output logic        TX,
  output logic        tx_done
);

  localparam bit             UseParity = (PARITY == 1) || (PARITY == 2);
  localparam bit             OddParity = (PARITY == 2);
  localparam logic [3:0]     LastStop  = (STOP_BITS == 2) ? 4'd1 : 4'd0;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e      state_q;
  logic [20:0] cnt_q;
  logic [20:0] period_q;
  logic [20:0] period_in;
  logic [7:0]  data_q;
  logic [3:0]  bit_idx_q;
  logic        parity_q;
  logic        frame_end_q;

  always_comb begin
    period_in = (prescaler_in < 21'd2) ? 21'd2 : prescaler_in;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      period_q    <= '0;
      data_q      <= '0;
      bit_idx_q   <= '0;
      parity_q    <= 1'b0;
      frame_end_q <= 1'b0;
      tx_ready    <= 1'b0;
      tx_done     <= 1'b0;
      TX          <= 1'b1;
    end else begin
      tx_done     <= 1'b0;
      frame_end_q <= 1'b0;
      case (state_q)
        StIdle: begin
          TX       <= 1'b1;
          tx_ready <= 1'b1;
          // Completion is reported one cycle after STOP ends so it lines up with the line.
          tx_done  <= frame_end_q;
          if (tx_valid && tx_ready) begin
            data_q    <= tx_data;
            period_q  <= period_in;
            cnt_q     <= period_in - 21'd1;
            bit_idx_q <= '0;
            parity_q  <= (^tx_data) ^ OddParity;
            tx_ready  <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          TX <= 1'b0;
          if (cnt_q == '0) begin
            cnt_q   <= period_q - 21'd1;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q - 21'd1;
          end
        end
        StData: begin
          TX <= data_q[bit_idx_q[2:0]];
          if (cnt_q == '0) begin
            cnt_q <= period_q - 21'd1;
            if (bit_idx_q == 4'd7) begin
              bit_idx_q <= '0;
              state_q   <= UseParity ? StParity : StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q - 21'd1;
          end
        end
        StParity: begin
          TX <= parity_q;
          if (cnt_q == '0) begin
            cnt_q   <= period_q - 21'd1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q - 21'd1;
          end
        end
        StStop: begin
          TX <= 1'b1;
          if (cnt_q == '0) begin
            if (bit_idx_q == LastStop) begin
              bit_idx_q   <= '0;
              frame_end_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              cnt_q     <= period_q - 21'd1;
            end
          end else begin
            cnt_q <= cnt_q - 21'd1;
          end
        end
        default: begin
          TX      <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no/even/odd parity and two stop bits.
// Sample k of a captured frame is the line value after the k-th edge following the handshake+1.
module tb_uart_tx;

  logic        CLK = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic [20:0] prescaler_in;
  logic [3:0]  tx_valid;
  logic [3:0]  tx_ready;
  logic [3:0]  TX;
  logic [3:0]  tx_done;

  int checks = 0;
  int errors = 0;

  logic line_s [0:127];
  logic done_s [0:127];

  always #5 CLK = ~CLK;

  uart_tx #(.PARITY(0), .STOP_BITS(1)) u_dut0 (
    .CLK(CLK), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .prescaler_in(prescaler_in), .TX(TX[0]), .tx_done(tx_done[0])
  );
  uart_tx #(.PARITY(1), .STOP_BITS(1)) u_dut1 (
    .CLK(CLK), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .prescaler_in(prescaler_in), .TX(TX[1]), .tx_done(tx_done[1])
  );
  uart_tx #(.PARITY(2), .STOP_BITS(1)) u_dut2 (
    .CLK(CLK), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .prescaler_in(prescaler_in), .TX(TX[2]), .tx_done(tx_done[2])
  );
  uart_tx #(.PARITY(0), .STOP_BITS(2)) u_dut3 (
    .CLK(CLK), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
    .prescaler_in(prescaler_in), .TX(TX[3]), .tx_done(tx_done[3])
  );

  // Expected line level k cycles after TX falls, for bit period p.
  function automatic logic exp_line(input logic [7:0] d, input int p, input int pmode,
                                    input int k);
    int b;
    b = k / p;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pmode != 0 && b == 9) return (^d) ^ (pmode == 2);
    return 1'b1;
  endfunction

  task automatic run_frame(input int dut, input logic [7:0] d, input logic [20:0] psc,
                           input int ncyc, input bit scramble);
    int w;
    w = 0;
    @(negedge CLK);
    while (tx_ready[dut] !== 1'b1 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    checks++;
    if (tx_ready[dut] !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait dut%0d: tx_ready=%b, required 1", dut, tx_ready[dut]);
    end
    tx_data      = d;
    prescaler_in = psc;
    tx_valid[dut] = 1'b1;
    @(negedge CLK);
    tx_valid[dut] = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge CLK);
      line_s[k] = TX[dut];
      done_s[k] = tx_done[dut];
      if (scramble && k == 5) begin
        tx_data      = ~d;
        prescaler_in = 21'd7;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_valid = 4'hF;
    tx_data = 8'h00;
    prescaler_in = 21'd4;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX !== 4'hF) begin
      errors++; $display("FAIL reset_tx: TX=%b, required 1111", TX);
    end
    checks++;
    if (tx_ready !== 4'h0) begin
      errors++; $display("FAIL reset_ready: tx_ready=%b, required 0000", tx_ready);
    end
    checks++;
    if (tx_done !== 4'h0) begin
      errors++; $display("FAIL reset_done: tx_done=%b, required 0000", tx_done);
    end
    tx_valid = 4'h0;
    rst = 1'b0;
    @(negedge CLK);
    checks++;
    if (tx_ready !== 4'hF || TX !== 4'hF) begin
      errors++;
      $display("FAIL reset_release: tx_ready=%b TX=%b, required 1111 1111", tx_ready, TX);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d [0:1];
    int p [0:1];
    int bad;
    d[0] = 8'h55; p[0] = 4;
    d[1] = 8'hC6; p[1] = 3;
    for (int t = 0; t < 2; t++) begin
      run_frame(0, d[t], p[t][20:0], 10 * p[t] + 3, 1'b0);
      bad = -1;
      for (int k = 0; k < 10 * p[t] + 3; k++)
        if (bad < 0 && (line_s[k] !== exp_line(d[t], p[t], 0, k) ||
                        done_s[k] !== (k == 10 * p[t]))) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL basic_%h: cycle %0d TX=%b done=%b, required TX=%b done=%b", d[t], bad,
                 line_s[bad], done_s[bad], exp_line(d[t], p[t], 0, bad), bad == 10 * p[t]);
      end
    end
  endtask

  task automatic test_parity();
    int bad;
    for (int m = 1; m <= 2; m++) begin
      run_frame(m, 8'hA3, 21'd3, 36, 1'b0);
      checks++;
      if (line_s[27] !== logic'(m == 2)) begin
        errors++;
        $display("FAIL parity_bit_mode%0d: TX=%b, required %b", m, line_s[27], m == 2);
      end
      bad = -1;
      for (int k = 0; k < 36; k++)
        if (bad < 0 && (line_s[k] !== exp_line(8'hA3, 3, m, k) || done_s[k] !== (k == 33)))
          bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL parity_frame_mode%0d: cycle %0d TX=%b done=%b, required TX=%b done=%b",
                 m, bad, line_s[bad], done_s[bad], exp_line(8'hA3, 3, m, bad), bad == 33);
      end
    end
  endtask

  task automatic test_two_stop();
    int bad;
    run_frame(3, 8'hFF, 21'd5, 58, 1'b0);
    bad = -1;
    for (int k = 0; k < 58; k++)
      if (bad < 0 && (line_s[k] !== (k >= 5) || done_s[k] !== (k == 55))) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL two_stop: cycle %0d TX=%b done=%b, required TX=%b done=%b", bad,
               line_s[bad], done_s[bad], bad >= 5, bad == 55);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int bad;
    int ndone;
    logic e;
    w = 0;
    @(negedge CLK);
    while (tx_ready[0] !== 1'b1 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    tx_data = 8'h01;
    prescaler_in = 21'd2;
    tx_valid[0] = 1'b1;
    @(negedge CLK);
    tx_data = 8'h80;
    for (int k = 0; k < 45; k++) begin
      @(negedge CLK);
      line_s[k] = TX[0];
      done_s[k] = tx_done[0];
      if (k == 21) tx_valid[0] = 1'b0;
    end
    // Frame 1 at 0..19, ready/done cycle 20, handshake-to-line cycle 21, frame 2 from 22.
    bad = -1;
    ndone = 0;
    for (int k = 0; k < 45; k++) begin
      if (k < 20) e = exp_line(8'h01, 2, 0, k);
      else if (k < 22) e = 1'b1;
      else e = exp_line(8'h80, 2, 0, k - 22);
      if (bad < 0 && (line_s[k] !== e || done_s[k] !== (k == 20 || k == 42))) bad = k;
      if (done_s[k] === 1'b1) ndone++;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL back_to_back: cycle %0d TX=%b done=%b", bad, line_s[bad], done_s[bad]);
    end
    checks++;
    if (ndone != 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d pulses, required 2", ndone);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    int ndone;
    run_frame(0, 8'h35, 21'd4, 17, 1'b0);
    checks++;
    if (line_s[16] !== 1'b0) begin
      errors++; $display("FAIL mid_bit3: TX=%b, required 0", line_s[16]);
    end
    rst = 1'b1;
    @(negedge CLK);
    checks++;
    if (TX[0] !== 1'b1 || tx_ready[0] !== 1'b0 || tx_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: TX=%b ready=%b done=%b, required 1 0 0", TX[0], tx_ready[0],
               tx_done[0]);
    end
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    checks++;
    if (tx_ready[0] !== 1'b1) begin
      errors++; $display("FAIL mid_ready: tx_ready=%b, required 1", tx_ready[0]);
    end
    bad = 0;
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (TX[0] !== 1'b1) bad++;
      if (tx_done[0] !== 1'b0) ndone++;
    end
    checks++;
    if (bad != 0 || ndone != 0) begin
      errors++;
      $display("FAIL mid_quiet: %0d low cycles, %0d done cycles, required 0 0", bad, ndone);
    end
    run_frame(0, 8'h96, 21'd4, 43, 1'b0);
    bad = -1;
    for (int k = 0; k < 43; k++)
      if (bad < 0 && (line_s[k] !== exp_line(8'h96, 4, 0, k) || done_s[k] !== (k == 40)))
        bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL mid_resend: cycle %0d TX=%b done=%b", bad, line_s[bad], done_s[bad]);
    end
  endtask

  task automatic test_reset_priority();
    int bad;
    @(negedge CLK);
    rst = 1'b1;
    tx_valid[0] = 1'b1;
    tx_data = 8'h00;
    prescaler_in = 21'd2;
    @(negedge CLK);
    checks++;
    if (TX[0] !== 1'b1 || tx_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_priority: TX=%b ready=%b, required 1 0", TX[0], tx_ready[0]);
    end
    rst = 1'b0;
    tx_valid[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (TX[0] !== 1'b1 || tx_ready[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rst_priority_idle: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_clamp();
    logic [20:0] psc [0:1];
    int bad;
    psc[0] = 21'd0;
    psc[1] = 21'd1;
    for (int t = 0; t < 2; t++) begin
      // Second pass also rewrites tx_data and prescaler_in mid-frame.
      run_frame(0, 8'h0F, psc[t], 23, t == 1);
      bad = -1;
      for (int k = 0; k < 23; k++)
        if (bad < 0 && (line_s[k] !== exp_line(8'h0F, 2, 0, k) || done_s[k] !== (k == 20)))
          bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL clamp_psc%0d: cycle %0d TX=%b done=%b, required TX=%b done=%b", psc[t],
                 bad, line_s[bad], done_s[bad], exp_line(8'h0F, 2, 0, bad), bad == 20);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tx_valid = 4'h0;
    tx_data = 8'h00;
    prescaler_in = 21'd0;
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid();
    test_reset_priority();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter PARITY, default 0, parity mode: 0 = none, 1 = even, 2 = odd; any other value SHALL behave as 0.
- REQ-002: Parameter STOP_BITS, default 1, stop-bit count: 1 or 2; any other value SHALL behave as 1.
- REQ-003: CLK  input  1  single clock; all logic SHALL be on its rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: tx_data  input  8  byte to send; sampled only on handshake.
- REQ-006: tx_valid  input  1  request: tx_data is valid.
- REQ-007: tx_ready  output  1  block can accept a byte (registered).
- REQ-008: prescaler_in  input  21  bit period in CLK cycles; sampled only on handshake.
- REQ-009: TX  output  1  serial line, idle high (registered, glitch-free).
- REQ-010: tx_done  output  1  one-cycle pulse: frame completed.

Function
- REQ-011: Handshake SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_valid while tx_ready=0 SHALL be ignored (no queueing).
- REQ-012: On handshake the block SHALL latch tx_data, latch P = max(prescaler_in, 2), drive tx_ready=0, and enter START.
- REQ-013: Changes to tx_data or prescaler_in after handshake SHALL NOT affect the frame in progress.
- REQ-014: State machine: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
- REQ-015: TX SHALL be 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- REQ-016: TX SHALL go low on the first rising edge after the handshake edge.
- REQ-017: Each START, DATA-bit, PARITY, and STOP-bit period SHALL last exactly P cycles, timed by an internal 21-bit down-counter reloaded with P-1 at each bit boundary.
- REQ-018: Data SHALL be sent LSB first, 8 bits, with a 4-bit bit index.
- REQ-019: The parity bit SHALL be the XOR of the 8 data bits for even parity and its inverse for odd parity.
- REQ-020: STOP SHALL last STOP_BITS*P cycles.
- REQ-021: At the end of STOP, the state SHALL return to IDLE; in the next cycle tx_ready=1 and tx_done=1 for exactly one cycle.
- REQ-022: Frame length from TX falling to tx_done high SHALL be P*(10 + (PARITY!=0) + (STOP_BITS==2 ? 1 : 0)) cycles.
- REQ-023: Back-to-back transfer: if tx_valid=1 in the cycle tx_ready=1, the next start bit SHALL begin one cycle later, giving exactly one extra idle-high cycle between frames.
- REQ-024: prescaler_in values 0 and 1 SHALL be clamped to 2; 21'h1FFFFF SHALL be supported without overflow.

Reset
- REQ-025: While rst=1: TX=1, tx_ready=0, tx_done=0, state=IDLE, counters=0.
- REQ-026: tx_ready SHALL become 1 on the first rising edge with rst=0.
- REQ-027: Reset asserted mid-frame SHALL abandon the frame: TX=1 on the next edge and no tx_done for that frame.
- REQ-028: rst SHALL take priority over a simultaneous handshake.

Verification
- REQ-029: PARITY=0, STOP_BITS=1, P=4, send 0x55 -> TX = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx_done 40 cycles after TX falls.
- REQ-030: PARITY=1, P=3, send 0xA3 -> parity bit 0; frame 33 cycles. PARITY=2, same byte -> parity bit 1.
- REQ-031: STOP_BITS=2, P=5, send 0xFF -> TX low for 5 cycles then high for 50 cycles; tx_done at cycle 55.
- REQ-032: tx_valid held high with 0x01 then 0x80, P=2 -> two frames with exactly one idle cycle between them; 0x01 and 0x80 correct on the line; two tx_done pulses.
- REQ-033: rst pulsed during bit 3 of a frame -> TX=1 next cycle, no tx_done, tx_ready=1 one cycle after rst falls; a new frame then sends correctly.
- REQ-034: prescaler_in=0, send 0x0F -> every bit lasts 2 cycles; prescaler_in changed mid-frame -> timing unchanged.
